// File: rtl/qpsk_pkg.sv
// Shared constants and types for the QPSK frame scheduler.
// QPSK_LOOPBACK_CHECK_EN adds the launched word to each in-flight entry.
package qpsk_pkg;
    localparam int QPSK_WORD_W  = 40;
    localparam int QPSK_STAMP_W = 16;

`ifdef QPSK_LOOPBACK_CHECK_EN
    typedef struct packed {
        logic [QPSK_WORD_W-1:0]  data;
        logic [QPSK_STAMP_W-1:0] stamp;
    } qpsk_entry_t;
`else
    typedef struct packed {
        logic [QPSK_STAMP_W-1:0] stamp;
    } qpsk_entry_t;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } qpsk_state_e;
endpackage

// File: rtl/qpsk_inflight_fifo.sv
// Synchronous FIFO holding launched-word entries until their capture time.
module qpsk_inflight_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [W-1:0]             din_i,
    input  logic                     pop_i,
    output logic [W-1:0]             head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/qpsk_frame_sched.sv
// Frame scheduler and loopback capture for the QPSK modem pair.
// QPSK_LOOPBACK_CHECK_EN enables m_err/err_cnt comparison of captured vs launched words.
//   state  | meaning
//   IDLE   | nothing launched, queue empty
//   ACTIVE | last boundary launched a word
//   DRAIN  | no new words, waiting for in-flight captures
module qpsk_frame_sched
    import qpsk_pkg::*;
#(
    parameter int                     FRAME_CYCLES = 20,
    parameter int                     LAT_CYCLES   = 45,
    parameter int                     DEPTH        = 4,
    parameter logic [QPSK_WORD_W-1:0] IDLE_WORD    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [QPSK_WORD_W-1:0] s_data,
    output logic [QPSK_WORD_W-1:0] para_in,
    input  logic [QPSK_WORD_W-1:0] para_out,
    output logic                   m_valid,
    output logic [QPSK_WORD_W-1:0] m_data,
    output logic                   busy
`ifdef QPSK_LOOPBACK_CHECK_EN
    ,
    output logic                   m_err,
    output logic [15:0]            err_cnt
`endif
);
    localparam int FW = $clog2(FRAME_CYCLES);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [FW-1:0]           FLAST     = FW'(FRAME_CYCLES - 1);
    localparam logic [QPSK_STAMP_W-1:0] LAT_STAMP = QPSK_STAMP_W'(LAT_CYCLES);

    logic [FW-1:0]           fcnt_q;
    logic [QPSK_STAMP_W-1:0] tmr_q;
    logic [QPSK_WORD_W-1:0]  para_in_q;
    logic [QPSK_WORD_W-1:0]  m_data_q;
    logic                    m_valid_q;
    logic                    busy_q;
    qpsk_state_e             state_q;

    qpsk_entry_t push_entry;
    qpsk_entry_t head;
    logic        full;
    logic        empty;
    logic [CW-1:0] count;
    logic        boundary;
    logic        xfer;
    logic        pop;
    logic        drained;

    assign boundary = (fcnt_q == FLAST);
    assign s_ready  = boundary && !full;
    assign xfer     = s_valid && s_ready;
    // Modular subtraction keeps the age correct across the timer wrap.
    assign pop      = !empty && ((tmr_q - head.stamp) == LAT_STAMP);
    assign drained  = !xfer && (empty || (pop && count == CW'(1)));

    always_comb begin
        push_entry       = '0;
        push_entry.stamp = tmr_q + QPSK_STAMP_W'(1);
`ifdef QPSK_LOOPBACK_CHECK_EN
        push_entry.data  = s_data;
`endif
    end

    qpsk_inflight_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(qpsk_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (xfer),
        .din_i   (push_entry),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q    <= '0;
            tmr_q     <= '0;
            para_in_q <= IDLE_WORD;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            fcnt_q    <= boundary ? '0 : fcnt_q + FW'(1);
            tmr_q     <= tmr_q + QPSK_STAMP_W'(1);
            m_valid_q <= pop;
            if (boundary) para_in_q <= xfer ? s_data : IDLE_WORD;
            if (pop)      m_data_q  <= para_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        state_q <= ACTIVE;
                        busy_q  <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (boundary && !xfer) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (xfer) begin
                        state_q <= ACTIVE;
                    end else if (drained) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef QPSK_LOOPBACK_CHECK_EN
    logic        m_err_q;
    logic [15:0] err_cnt_q;
    logic        mismatch;

    assign mismatch = pop && (para_out != head.data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_err_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            m_err_q <= mismatch;
            if (mismatch && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign m_err   = m_err_q;
    assign err_cnt = err_cnt_q;
`endif

    assign para_in = para_in_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign busy    = busy_q;
endmodule

// File: tb/tb_qpsk_frame_sched.sv
// Bench for qpsk_frame_sched: modem modelled as a 45-cycle delay line, outputs checked every cycle
// against a word-level model (accept at frame end, deliver LAT+2 cycles later).
module tb_qpsk_frame_sched;
    localparam int FRAME = 20;
    localparam int LAT   = 45;
    localparam int DEPTH = 4;
    localparam logic [39:0] IDLE = 40'hA5_5A00_FF00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [39:0] s_data = '0;
    logic [39:0] para_in;
    logic [39:0] para_out;
    logic        m_valid;
    logic [39:0] m_data;
    logic        busy;
`ifdef QPSK_LOOPBACK_CHECK_EN
    logic        m_err;
    logic [15:0] err_cnt;
`endif

    qpsk_frame_sched #(
        .FRAME_CYCLES (FRAME),
        .LAT_CYCLES   (LAT),
        .DEPTH        (DEPTH),
        .IDLE_WORD    (IDLE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .para_in  (para_in),
        .para_out (para_out),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .busy     (busy)
`ifdef QPSK_LOOPBACK_CHECK_EN
        ,
        .m_err    (m_err),
        .err_cnt  (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;
    int cyc;
    int flip_cyc = -1;
    int pulse_cnt = 0;
    int drop_cnt = 0;
    logic prev_busy = 1'b0;

    // Modem: para_out follows para_in LAT cycles later, optional bit-0 flip on one cycle.
    logic [39:0] sr [LAT];
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) sr[i] <= sr[i-1];
        sr[0] <= para_in;
    end
    assign para_out = sr[LAT-1] ^ {39'd0, (cyc == flip_cyc)};

    // Word-level reference: accepted words with their acceptance cycle.
    int          acc_cyc[$];
    logic [39:0] acc_dat[$];
    logic [39:0] exp_pin;
    logic [39:0] last_md;
    int          err_exp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc <= 0;
            acc_cyc.delete();
            acc_dat.delete();
            exp_pin = IDLE;
            last_md = '0;
            err_exp = 0;
        end else begin
            if (cyc % FRAME == FRAME - 1) begin
                if (s_valid && acc_cyc.size() < DEPTH) begin
                    acc_cyc.push_back(cyc);
                    acc_dat.push_back(s_data);
                    exp_pin = s_data;
                end else begin
                    exp_pin = IDLE;
                end
            end
            cyc <= cyc + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    endtask

    always @(negedge clk) begin : chk
        logic exp_v;
        logic exp_busy;
        logic flipped;
        if (rst_n) begin
            exp_v    = 1'b0;
            exp_busy = 1'b0;
            flipped  = 1'b0;
            foreach (acc_cyc[i]) if (acc_cyc[i] + LAT + 1 >= cyc) exp_busy = 1'b1;
            if (acc_cyc.size() > 0 && acc_cyc[0] + LAT + 2 == cyc) begin
                exp_v   = 1'b1;
                flipped = (acc_cyc[0] + LAT + 1 == flip_cyc);
                last_md = acc_dat[0] ^ {39'd0, flipped};
                if (flipped && err_exp < 65535) err_exp++;
                void'(acc_cyc.pop_front());
                void'(acc_dat.pop_front());
            end
            check("s_ready", s_ready, (cyc % FRAME == FRAME - 1));
            check("para_in", para_in, exp_pin);
            check("m_valid", m_valid, exp_v);
            check("m_data", m_data, last_md);
            check("busy", busy, exp_busy);
`ifdef QPSK_LOOPBACK_CHECK_EN
            check("m_err", m_err, exp_v && flipped);
            check("err_cnt", err_cnt, err_exp);
`endif
            if (m_valid) pulse_cnt++;
            if (prev_busy && !busy) drop_cnt++;
            prev_busy = busy;
        end
    end

    task automatic do_reset();
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        flip_cyc = -1;
        prev_busy = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        pulse_cnt = 0;
        drop_cnt  = 0;
    endtask

    task automatic wait_cyc(input int n);
        int g = 0;
        while (cyc < n && g < 100000) begin
            @(negedge clk);
            g++;
        end
        if (cyc != n) begin
            n_chk++;
            $display("FAIL wait_cyc actual=%0d required=%0d", cyc, n);
        end
    endtask

    // Present one frame's worth of source data mid-frame; held across the boundary.
    task automatic drive_frame(input logic v, input logic [39:0] d);
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (cyc % FRAME != 5 && g < 2 * FRAME);
        s_valid = v;
        s_data  = d;
    endtask

    typedef struct {
        logic [7:0]  plan;
        logic [39:0] seed;
        int          exp_pulses;
        int          exp_drops;
    } vec_t;
    vec_t vecs[7];

    initial begin
        logic [39:0] w;
        int n_sent;
        vecs[0] = '{8'b0000_0001, 40'h11_0000_0001, 1, 1};
        vecs[1] = '{8'b1111_1111, 40'h22_F0F0_0000, 8, 1};
        vecs[2] = '{8'b0000_0101, 40'h33_1234_5678, 2, 1};
        vecs[3] = '{8'b0000_1001, 40'h44_8765_4321, 2, 2};
        vecs[4] = '{8'b1000_0001, 40'h55_AAAA_5555, 2, 2};
        vecs[5] = '{8'b0000_0000, 40'h66_0000_0000, 0, 0};
        vecs[6] = '{8'b0011_0011, 40'hFF_FFFF_FFF0, 4, 2};

        // Single word held from reset, then reset while two words are in flight.
        rst_n   = 1'b0;
        s_valid = 1'b1;
        s_data  = 40'h12_3456_789A;
        repeat (2) @(negedge clk);
        check("rst_para_in", para_in, IDLE);
        check("rst_busy", busy, 1'b0);
        check("rst_s_ready", s_ready, 1'b0);
        rst_n = 1'b1;
        wait_cyc(19);
        check("t1_ready19", s_ready, 1'b1);
        wait_cyc(20);
        check("t1_para_in20", para_in, 40'h12_3456_789A);
        s_valid = 1'b0;
        wait_cyc(65);
        check("t1_valid65", m_valid, 1'b0);
        check("t1_busy65", busy, 1'b1);
        wait_cyc(66);
        check("t1_valid66", m_valid, 1'b1);
        check("t1_data66", m_data, 40'h12_3456_789A);
        check("t1_busy66", busy, 1'b0);
        drive_frame(1'b1, 40'h01_0203_0405);
        drive_frame(1'b1, 40'h06_0708_090A);
        drive_frame(1'b0, '0);
        wait_cyc(130);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_para_in", para_in, IDLE);
        check("midrst_m_data", m_data, 40'd0);
        check("midrst_m_valid", m_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_s_ready", s_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse_cnt = 0;
        wait_cyc(120);
        check("midrst_no_pulse", pulse_cnt, 0);

        // Error injection on the first capture only.
        do_reset();
        flip_cyc = 65;
        drive_frame(1'b1, 40'hC0_FFEE_0001);
        drive_frame(1'b0, '0);
        drive_frame(1'b1, 40'hC0_FFEE_0002);
        drive_frame(1'b0, '0);
        wait_cyc(66);
        check("err_flipped_data", m_data, 40'hC0_FFEE_0000);
`ifdef QPSK_LOOPBACK_CHECK_EN
        check("err_m_err_first", m_err, 1'b1);
`endif
        wait_cyc(106);
        check("err_clean_data", m_data, 40'hC0_FFEE_0002);
`ifdef QPSK_LOOPBACK_CHECK_EN
        check("err_m_err_second", m_err, 1'b0);
        check("err_cnt_final", err_cnt, 16'd1);
`endif

        // Frame-pattern table.
        foreach (vecs[i]) begin
            do_reset();
            for (int k = 0; k < 8; k++) drive_frame(vecs[i].plan[k], vecs[i].seed + 40'(k));
            drive_frame(1'b0, '0);
            wait_cyc(235);
            check("vec_pulses", pulse_cnt, vecs[i].exp_pulses);
            check("vec_busy_drops", drop_cnt, vecs[i].exp_drops);
        end

        // Long random run crossing the 16-bit timer wrap.
        do_reset();
        n_sent = 0;
        for (int f = 0; f < 3300; f++) begin
            w = {8'($urandom), $urandom};
            if ($urandom_range(3) != 0) begin
                drive_frame(1'b1, w);
                n_sent++;
            end else begin
                drive_frame(1'b0, w);
            end
        end
        drive_frame(1'b0, '0);
        wait_cyc(3300 * FRAME + 80);
        check("rand_pulses", pulse_cnt, n_sent);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
